// File: rtl/reg_bank_p.sv
// Register bank with write-first read bypass, live special-register copies
// and a small memory handshake FSM that loads/stores the working register.
module reg_bank_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 36,
  parameter int WR_IDX   = 34,
  parameter int AUX_IDX  = 35,
  parameter int PO0_IDX  = 30,
  parameter int PO1_IDX  = 31,
  parameter int PI0_IDX  = 32,
  parameter int PI1_IDX  = 33,
  parameter bit ZERO_R0  = 1'b1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [ADDR_W-1:0] bus_b,
  input  logic              rd_en,
  input  logic              wr_rd_en,
  input  logic [ADDR_W-1:0] bus_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic              reg_wr,
  input  logic              work_wr,
  input  logic [1:0]        mc,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mdata,
  input  logic [DATA_W-1:0] pi0,
  input  logic [DATA_W-1:0] pi1,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              busy,
  output logic [DATA_W-1:0] wr_current,
  output logic [DATA_W-1:0] aux_reg,
  output logic [DATA_W-1:0] po0,
  output logic [DATA_W-1:0] po1
);

  typedef enum logic [1:0] {IDLE, MWRITE, MREAD} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] regs_nxt [NUM_REGS];
  logic              gen_we;
  logic              work_we;
  logic              mrd_done;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  function automatic logic addr_is(input logic [ADDR_W-1:0] addr, input int idx);
    return addr == ADDR_W'(idx);
  endfunction

  always_comb begin
    mrd_done = (state == MREAD) && mem_ack;
    gen_we   = reg_wr && !addr_is(bus_c, WR_IDX) && !addr_is(bus_c, AUX_IDX) &&
               !addr_is(bus_c, PI0_IDX) && !addr_is(bus_c, PI1_IDX) &&
               (int'(bus_c) < NUM_REGS) && !(ZERO_R0 && (bus_c == '0));
    // Memory read-back owns the working register on its completion edge.
    work_we  = work_wr && addr_is(bus_c, WR_IDX) && !busy && !mrd_done;
  end

  // Next register image: everything downstream reads this so writes bypass.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_nxt[i] = regs[i];
    if (gen_we) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (addr_is(bus_c, i)) regs_nxt[i] = data_c;
    end
    if (mrd_done)     regs_nxt[WR_IDX] = mdata;
    else if (work_we) regs_nxt[WR_IDX] = data_c;
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_is(bus_a, i)) rd_a = regs_nxt[i];
      if (addr_is(bus_b, i)) rd_b = regs_nxt[i];
    end
    if (addr_is(bus_a, PI0_IDX)) rd_a = pi0;
    if (addr_is(bus_a, PI1_IDX)) rd_a = pi1;
    if (addr_is(bus_b, PI0_IDX)) rd_b = pi0;
    if (addr_is(bus_b, PI1_IDX)) rd_b = pi1;
    if (ZERO_R0 && (bus_a == '0)) rd_a = '0;
    if (ZERO_R0 && (bus_b == '0)) rd_b = '0;
  end

  // Registered state, operands, live copies and memory FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      a          <= '0;
      b          <= '0;
      wr_data    <= '0;
      wr_current <= '0;
      aux_reg    <= '0;
      po0        <= '0;
      po1        <= '0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
      if (rd_en || wr_rd_en) begin
        a <= rd_a;
        b <= rd_b;
      end
      wr_current <= regs_nxt[WR_IDX];
      aux_reg    <= regs_nxt[AUX_IDX];
      po0        <= regs_nxt[PO0_IDX];
      po1        <= regs_nxt[PO1_IDX];
      case (state)
        IDLE: begin
          if (mc[0]) begin
            state   <= MWRITE;
            wr_data <= regs_nxt[WR_IDX];
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end else if (mc[1]) begin
            state   <= MREAD;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        MWRITE, MREAD: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_p.sv
// Bench for reg_bank_p: vector table through a scoreboard queue, then
// hand-written memory handshake and reset sequences.
module tb_reg_bank_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  bus_a, bus_b, bus_c;
  logic        rd_en, wr_rd_en, reg_wr, work_wr, mem_ack;
  logic [15:0] data_c, mdata, pi0, pi1;
  logic [1:0]  mc;
  logic [15:0] a, b, wr_data, wr_current, aux_reg, po0, po1;
  logic        mem_req, busy;

  int passed = 0;
  int total  = 0;

  reg_bank_p dut (
    .clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_b(bus_b), .rd_en(rd_en),
    .wr_rd_en(wr_rd_en), .bus_c(bus_c), .data_c(data_c), .reg_wr(reg_wr),
    .work_wr(work_wr), .mc(mc), .mem_ack(mem_ack), .mdata(mdata), .pi0(pi0),
    .pi1(pi1), .a(a), .b(b), .wr_data(wr_data), .mem_req(mem_req), .busy(busy),
    .wr_current(wr_current), .aux_reg(aux_reg), .po0(po0), .po1(po1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, ww, rd, wrd;
    logic [5:0]  ba, bb, bc;
    logic [15:0] dc, p0;
    logic [15:0] ea, eb, ewc, ep0;
  } vec_t;

  typedef struct {
    logic [15:0] a, b, wc, p0;
  } exp_t;

  vec_t vecs [11];
  exp_t sbq [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic idle_inputs();
    reg_wr = 0; work_wr = 0; rd_en = 0; wr_rd_en = 0; mc = 2'b00; mem_ack = 0;
    bus_a = 0; bus_b = 0; bus_c = 0; data_c = 0; mdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 6'd0, 6'd0, 6'd5,  16'h00F0,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0, 6'd5, 6'd0, 6'd0,  16'h0000,16'h0000, 16'h00F0,16'h0000,16'h0000,16'h0000};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0, 6'd7, 6'd7, 6'd7,  16'h1234,16'h0000, 16'h1234,16'h1234,16'h0000,16'h0000};
    vecs[3]  = '{1'b1,1'b0,1'b1,1'b0, 6'd35,6'd5, 6'd35, 16'hFFFF,16'h0000, 16'h0000,16'h00F0,16'h0000,16'h0000};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0, 6'd32,6'd33,6'd32, 16'hFFFF,16'hA5A5, 16'hA5A5,16'h5A5A,16'h0000,16'h0000};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0, 6'd0, 6'd40,6'd0,  16'hFFFF,16'hA5A5, 16'h0000,16'h0000,16'h0000,16'h0000};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 6'd0, 6'd0, 6'd30, 16'hC0DE,16'h0000, 16'h0000,16'h0000,16'h0000,16'hC0DE};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0, 6'd34,6'd30,6'd34, 16'h000F,16'h0000, 16'h000F,16'hC0DE,16'h000F,16'hC0DE};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1, 6'd5, 6'd34,6'd5,  16'h7777,16'h0000, 16'h00F0,16'h000F,16'h000F,16'hC0DE};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b0, 6'd34,6'd31,6'd34, 16'h9999,16'h0000, 16'h000F,16'h0000,16'h000F,16'hC0DE};
    vecs[10] = '{1'b1,1'b0,1'b1,1'b0, 6'd63,6'd32,6'd63, 16'h0001,16'h1357, 16'h0000,16'h1357,16'h000F,16'hC0DE};

    idle_inputs();
    pi0 = 16'h0000;
    pi1 = 16'h5A5A;
    rst_n = 0;
    reg_wr = 1; bus_c = 6'd5; data_c = 16'hFFFF; rd_en = 1; bus_a = 6'd33; mc = 2'b10;
    step();
    step();
    check("rst_a", a, 16'h0);
    check("rst_b", b, 16'h0);
    check("rst_mem_req", {15'b0, mem_req}, 16'h0);
    check("rst_busy", {15'b0, busy}, 16'h0);
    check("rst_aux", aux_reg, 16'h0);

    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      reg_wr = vecs[i].rw; work_wr = vecs[i].ww; rd_en = vecs[i].rd; wr_rd_en = vecs[i].wrd;
      bus_a = vecs[i].ba; bus_b = vecs[i].bb; bus_c = vecs[i].bc;
      data_c = vecs[i].dc; pi0 = vecs[i].p0;
      sbq.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].ewc, vecs[i].ep0});
      step();
      if (sbq.size() == 0) begin
        check($sformatf("v%0d_sb_empty", i), 16'h1, 16'h0);
      end else begin
        e = sbq.pop_front();
        check($sformatf("v%0d_a", i), a, e.a);
        check($sformatf("v%0d_b", i), b, e.b);
        check($sformatf("v%0d_wr_current", i), wr_current, e.wc);
        check($sformatf("v%0d_po0", i), po0, e.p0);
      end
    end

    // Memory write: busy blocks work_wr and mc, other writes proceed.
    idle_inputs();
    mc = 2'b01;
    step();
    check("mw_mem_req", {15'b0, mem_req}, 16'h1);
    check("mw_busy", {15'b0, busy}, 16'h1);
    check("mw_wr_data", wr_data, 16'h000F);
    mc = 2'b00; work_wr = 1; bus_c = 6'd34; data_c = 16'h2222;
    step();
    work_wr = 0; reg_wr = 1; bus_c = 6'd31; data_c = 16'h4321; mc = 2'b10;
    step();
    reg_wr = 0; mc = 2'b00; mem_ack = 1;
    step();
    check("mw_done_req", {15'b0, mem_req}, 16'h0);
    check("mw_done_busy", {15'b0, busy}, 16'h0);
    check("mw_work_blocked", wr_current, 16'h000F);
    check("mw_po1", po1, 16'h4321);
    check("mw_wr_data_hold", wr_data, 16'h000F);
    mem_ack = 0;
    step();
    check("mw_mc_ignored", {15'b0, mem_req}, 16'h0);

    // mc=11 acts as a memory write: no load from mdata.
    mc = 2'b11; mdata = 16'hDEAD;
    step();
    check("mc11_busy", {15'b0, busy}, 16'h1);
    mc = 2'b00; mem_ack = 1;
    step();
    mem_ack = 0;
    check("mc11_no_load", wr_current, 16'h000F);
    check("mc11_done", {15'b0, busy}, 16'h0);

    // Memory read wins over a same-edge work_wr.
    mc = 2'b10; mdata = 16'hBEEF;
    step();
    check("mr_busy", {15'b0, busy}, 16'h1);
    check("mr_mem_req", {15'b0, mem_req}, 16'h1);
    mc = 2'b00; mem_ack = 1; work_wr = 1; bus_c = 6'd34; data_c = 16'h1111;
    rd_en = 1; bus_a = 6'd34; bus_b = 6'd30;
    step();
    check("mr_wr_current", wr_current, 16'hBEEF);
    check("mr_bypass_a", a, 16'hBEEF);
    check("mr_done_busy", {15'b0, busy}, 16'h0);
    idle_inputs();
    mem_ack = 1;
    step();
    check("ack_idle_req", {15'b0, mem_req}, 16'h0);
    check("ack_idle_wrc", wr_current, 16'hBEEF);

    // Reset during MREAD completion aborts the load.
    idle_inputs();
    mc = 2'b10;
    step();
    mc = 2'b00;
    check("rr_busy", {15'b0, busy}, 16'h1);
    mdata = 16'hCAFE; mem_ack = 1; rst_n = 0;
    reg_wr = 1; bus_c = 6'd30; data_c = 16'h1111; rd_en = 1; bus_a = 6'd7;
    step();
    check("rr_a", a, 16'h0);
    check("rr_b", b, 16'h0);
    check("rr_wr_data", wr_data, 16'h0);
    check("rr_wr_current", wr_current, 16'h0);
    check("rr_po0", po0, 16'h0);
    check("rr_po1", po1, 16'h0);
    check("rr_mem_req", {15'b0, mem_req}, 16'h0);
    check("rr_busy_clr", {15'b0, busy}, 16'h0);
    rst_n = 1; reg_wr = 0; rd_en = 1; bus_a = 6'd7; bus_b = 6'd34;
    step();
    check("post_rr_a", a, 16'h0);
    check("post_rr_b", b, 16'h0);
    check("post_rr_wrc", wr_current, 16'h0);
    check("post_rr_req", {15'b0, mem_req}, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_bank_p.md
REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: register and bus data width.
REQ-002 SHALL provide parameter NUM_REGS, default 36: register count; ADDR_W = clog2(NUM_REGS), default 6.
REQ-003 SHALL provide parameters WR_IDX=34, AUX_IDX=35, PO0_IDX=30, PO1_IDX=31, PI0_IDX=32, PI1_IDX=33: special register indices.
REQ-004 SHALL provide parameter ZERO_R0, default 1: 1 = register 0 reads as zero and ignores writes.
REQ-005 Ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-006 Ports: bus_a in ADDR_W, bus_b in ADDR_W: read addresses; rd_en in 1: read strobe; wr_rd_en in 1: working-register read strobe.
REQ-007 Ports: bus_c in ADDR_W, data_c in DATA_W: write address/data; reg_wr in 1: general write enable; work_wr in 1: working-register write enable.
REQ-008 Ports: mc in 2: bit0 memory-write request, bit1 memory-read request; mem_ack in 1: memory done; mdata in DATA_W: memory read data.
REQ-009 Ports: pi0, pi1 in DATA_W: input ports.
REQ-010 Ports: a, b out DATA_W: operands; wr_data out DATA_W: memory write data; mem_req out 1; busy out 1.
REQ-011 Ports: wr_current, aux_reg, po0, po1 out DATA_W: live copies of registers WR_IDX, AUX_IDX, PO0_IDX, PO1_IDX.

Function
REQ-012 All state SHALL update only on rising clk; no latches; no level-sensitive write blocks.
REQ-013 General write: reg_wr=1, bus_c != WR_IDX, AUX_IDX, PI0_IDX, PI1_IDX, bus_c < NUM_REGS -> Register[bus_c] <= data_c next edge.
REQ-014 Working write: work_wr=1 and bus_c == WR_IDX -> Register[WR_IDX] <= data_c; work_wr with any other bus_c SHALL be ignored.
REQ-015 Writes to AUX_IDX via bus_c SHALL be ignored (reserved index); out-of-range bus_c and writes to register 0 with ZERO_R0=1 ignored.
REQ-016 Reads: rd_en or wr_rd_en high at edge -> a <= value(bus_a), b <= value(bus_b); 1-cycle latency; otherwise a, b hold.
REQ-017 Read value of PI0_IDX/PI1_IDX SHALL be pi0/pi1 sampled at that edge; out-of-range index reads 0.
REQ-018 Read-during-write same index same edge SHALL return data_c (write-first bypass), for a and b independently.
REQ-019 wr_current, aux_reg, po0, po1 SHALL be registered, reflecting Register contents including the current edge's write (bypassed), 1-cycle latency from write.
REQ-020 Memory FSM states IDLE, MWRITE, MREAD; reset -> IDLE.
REQ-021 IDLE, mc=01 -> MWRITE, wr_data <= Register[WR_IDX] (bypassed), mem_req <= 1, busy <= 1.
REQ-022 IDLE, mc=10 -> MREAD, mem_req <= 1, busy <= 1; mc=11 SHALL be treated as mc=01 (write priority); mc=00 stays IDLE.
REQ-023 MWRITE, mem_ack=1 -> IDLE, mem_req <= 0, busy <= 0; wr_data holds until next MWRITE entry.
REQ-024 MREAD, mem_ack=1 -> Register[WR_IDX] <= mdata, -> IDLE, mem_req <= 0, busy <= 0.
REQ-025 mem_ack in IDLE SHALL be ignored; mc changes while busy SHALL be ignored.
REQ-026 While busy, work_wr SHALL be ignored; reg_wr to other indices and all reads SHALL proceed.
REQ-027 MREAD completion and work_wr same edge: memory data SHALL win.

Reset
REQ-028 rst_n=0 at edge SHALL clear all registers, a, b, wr_data, wr_current, aux_reg, po0, po1 to 0, mem_req=0, busy=0, FSM=IDLE.
REQ-029 Reset mid-transfer SHALL abort: no Register update from mdata, mem_req low next cycle.
REQ-030 Reset SHALL dominate all concurrent writes, reads and mem_ack.

Verification
REQ-031 Reset, then reg_wr bus_c=5 data_c=0x00F0; next cycle rd_en bus_a=5 -> a=0x00F0 one cycle later.
REQ-032 reg_wr bus_c=7 data_c=0x1234 with rd_en bus_a=7 bus_b=7 same edge -> a=b=0x1234 next cycle.
REQ-033 work_wr bus_c=34 data_c=0x000F, then mc=01 -> mem_req=1, busy=1, wr_data=0x000F; mem_ack 3 cycles later -> mem_req=0, busy=0.
REQ-034 mc=10, mdata=0xBEEF, mem_ack -> wr_current=0xBEEF next cycle; same-edge work_wr 0x1111 discarded.
REQ-035 reg_wr bus_c=35 or 32, and bus_c=0 -> no change; rd_en bus_a=32 with pi0=0xA5A5 -> a=0xA5A5.
REQ-036 rst_n=0 during MREAD with mem_ack=1 -> all outputs 0, wr_current stays 0, FSM IDLE.
